// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them
// through the core's external instruction-memory port, then enables the core.
module imem_boot_loader #(
    parameter logic [63:0] BASE_ADDR   = 64'd0,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned TO_W        = 11
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    input  logic             stop,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic             cpu_enable,
    output logic             busy,
    output logic             error
);
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_RUN, S_ERROR} state_t;

    // Counter value one below the limit: the increment out of it is the timeout.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] count;
    logic [TO_W-1:0]  to_cnt;
    logic [63:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             accept;
    logic             last_word;

    assign accept    = byte_valid && (state == S_RECV);
    assign last_word = (word_idx == count - CNT_W'(1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = (word_count == '0) ? S_RUN : S_RECV;
                    end
                end
                S_RECV: begin
                    if (accept && byte_idx == 2'd3) begin
                        state_nxt = S_WRITE;
                    end else if (!accept && to_cnt == TO_LAST) begin
                        state_nxt = S_ERROR;
                    end
                end
                S_WRITE: state_nxt = last_word ? S_RUN : S_RECV;
                S_RUN: begin
                    if (stop) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_ERROR: state_nxt = S_ERROR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            byte_idx <= '0;
            word_idx <= '0;
            count    <= '0;
            to_cnt   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && word_count != '0) begin
                        count    <= word_count;
                        byte_idx <= '0;
                        word_idx <= '0;
                        to_cnt   <= '0;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        wdata_q[{byte_idx, 3'b000} +: 8] <= byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        to_cnt   <= '0;
                        // Address is staged with the last byte so it is stable for the whole WRITE cycle.
                        if (byte_idx == 2'd3) begin
                            addr_q <= BASE_ADDR + {{(62 - CNT_W){1'b0}}, word_idx, 2'b00};
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + CNT_W'(1);
                        byte_idx <= '0;
                        to_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready = (state == S_RECV);
    assign wen_ext    = (state == S_WRITE);
    assign ren_ext    = 1'b0;
    assign cpu_enable = (state == S_RUN);
    assign busy       = (state == S_RECV) || (state == S_WRITE);
    assign error      = (state == S_ERROR);
    assign addr_ext   = addr_q;
    assign wdata_ext  = wdata_q;
endmodule
